dio_edge_counter: RTL and testbench
===================================

DIO_EDGE_COUNTER -- requirements
Module: dio_edge_counter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports listed clock and reset first.
REQ-002 clk  in  1  core clock; all logic on the rising edge.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 dio_in  in  8  asynchronous DIO input pins 9-16 (bit 0 = pin 9).
REQ-005 enable  in  1  1 = gated counting runs; 0 = idle.
REQ-006 edge_mode  in  2  00 rising, 01 falling, 10 both, 11 count nothing.
REQ-007 gate_len  in  32  window length in clk cycles; 0 = no windows.
REQ-008 count_bus  out  128  latched per-pin counts, pin n at bits [16n+15:16n].
REQ-009 ovf  out  8  per-pin saturation flag for the latched window.
REQ-010 done  out  1  one-cycle pulse when count_bus/ovf are updated.
REQ-011 window_cnt  out  16  number of completed windows, wraps 0xFFFF->0.

Function
REQ-012 Each dio_in bit SHALL pass through a 2-flop synchronizer, then an edge detector comparing the synced value with its previous value.
REQ-013 An edge at a pin SHALL reach its accumulator 3 cycles after the pin changes, or 3 cycles plus filter latency when the glitch filter is built in.
REQ-014 The FSM SHALL have two states. IDLE -> RUN when enable=1 and gate_len!=0. RUN -> IDLE when enable=0 or gate_len=0.
REQ-015 On entry to RUN, accumulators SHALL clear and the timer SHALL load gate_len-1.
REQ-016 In RUN the timer SHALL decrement each cycle. At timer=0, in the same cycle:
- accumulator values, including any edge qualifying that cycle, transfer to count_bus/ovf;
- done=1;
- window_cnt increments;
- accumulators clear;
- the timer reloads from gate_len as sampled that cycle.
REQ-017 Windows SHALL be back-to-back with no dead cycle. An edge in the cycle after done counts in the new window.
REQ-018 gate_len=1 SHALL produce done every cycle, with each count equal to that cycle's edge (0 or 1).
REQ-019 Accumulators SHALL be 16-bit and saturate at 0xFFFF. The pin's ovf bit is set if a further edge arrives while saturated.
REQ-020 Leaving RUN mid-window SHALL discard the partial window with no done pulse. count_bus, ovf and window_cnt hold their values.
REQ-021 edge_mode changes SHALL take effect on the next cycle's edge qualification, without restarting the window.
REQ-022 Edges SHALL be ignored in IDLE.

Reset
REQ-023 Reset SHALL clear synchronizers, edge history, accumulators, timer, count_bus, ovf, window_cnt and done, and force IDLE.
REQ-024 After reset deassertion, edge detection SHALL be suppressed for 3 cycles so that a pin held high is not counted as an edge.
REQ-025 Reset asserted mid-window SHALL abort it without a done pulse.

Configuration
REQ-026 With DIO_EDGE_GLITCH_FILTER_EN defined, each synced pin SHALL pass a 3-sample stable filter: the output changes only after 3 consecutive equal samples. This adds 2 cycles of latency and rejects pulses shorter than 3 cycles.
REQ-027 Without DIO_EDGE_GLITCH_FILTER_EN, the filter SHALL be absent and latency SHALL be as in REQ-013 without filter.
REQ-028 Post-reset suppression SHALL cover the full pipeline depth in both builds: 3 cycles without the filter, 5 cycles with it.

Verification
REQ-029 gate_len=100, edge_mode=00, pin 0 toggling every 5 cycles -> count 10 (+/-1 at the boundary) every 100 cycles, done period exactly 100.
REQ-030 edge_mode=10, same stimulus -> count 20 +/-1; edge_mode=11 -> count 0 on all pins.
REQ-031 gate_len=0x20000, pin 3 toggling every cycle -> count 0xFFFF and ovf[3]=1; next window with the pin quiet -> count 0 and ovf[3]=0.
REQ-032 enable dropped at cycle 50 of a 100-cycle window -> no done pulse, count_bus unchanged; re-enable -> first done 100 cycles later.
REQ-033 dio_in=0xFF held through reset release with enable=1 and gate_len=10 -> first window reports all counts 0.
REQ-034 Filter build, 2-cycle glitch on pin 7 -> not counted; 3-cycle pulse -> counts 1 rising edge.

Source files
------------

// File: rtl/dio_edge_counter_if.sv
// Signal bundle for dio_edge_counter: DIO pins, window configuration and latched window results.
interface dio_edge_counter_if;
    logic [7:0]   dio_in;
    logic         enable;
    logic [1:0]   edge_mode;
    logic [31:0]  gate_len;
    logic [127:0] count_bus;
    logic [7:0]   ovf;
    logic         done;
    logic [15:0]  window_cnt;

    modport master (output dio_in, edge_mode, gate_len, enable,
                    input  count_bus, ovf, done, window_cnt);
    modport slave  (input  dio_in, edge_mode, gate_len, enable,
                    output count_bus, ovf, done, window_cnt);
endinterface

// File: rtl/dio_edge_counter.sv
// Gated per-pin edge counter for 8 DIO pins with back-to-back windows and saturating counts.
// Optional build macro DIO_EDGE_GLITCH_FILTER_EN adds a 3-sample stability filter per pin.
module dio_edge_counter (
    input  logic              clk,
    input  logic              reset,
    dio_edge_counter_if.slave bus
);
    // state | meaning
    // IDLE  | no window open, edges ignored, results hold
    // RUN   | window open, timer counts down, window closes when timer = 0
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

`ifdef DIO_EDGE_GLITCH_FILTER_EN
    localparam logic [2:0] SUPPRESS_CYCLES = 3'd5;
`else
    localparam logic [2:0] SUPPRESS_CYCLES = 3'd3;
`endif

    state_t           state_q, state_d;
    logic [7:0]       sync1_q, sync1_d, sync2_q, sync2_d;
    logic [7:0]       hist_q, hist_d;
    logic [2:0]       sup_q, sup_d;
    logic [31:0]      timer_q, timer_d;
    logic [7:0][15:0] acc_q, acc_d, acc_sum;
    logic [7:0]       aovf_q, aovf_d, aovf_sum;
    logic [7:0][15:0] count_q, count_d;
    logic [7:0]       ovf_q, ovf_d;
    logic             done_q, done_d;
    logic [15:0]      wcnt_q, wcnt_d;
    logic [7:0]       pin_now, rise, fall, qual;

`ifdef DIO_EDGE_GLITCH_FILTER_EN
    logic [7:0] h1_q, h1_d, h2_q, h2_d, stable;
`endif

    always_comb begin
        sync1_d = bus.dio_in;
        sync2_d = sync1_q;
        sup_d   = (sup_q != 3'd0) ? sup_q - 3'd1 : 3'd0;
`ifdef DIO_EDGE_GLITCH_FILTER_EN
        h1_d    = sync2_q;
        h2_d    = h1_q;
        // a pin's filtered level only moves once three successive samples agree
        stable  = ~(sync2_q ^ h1_q) & ~(h1_q ^ h2_q);
        pin_now = (stable & sync2_q) | (~stable & hist_q);
`else
        pin_now = sync2_q;
`endif
        hist_d  = pin_now;
        rise    = pin_now & ~hist_q;
        fall    = ~pin_now & hist_q;
        case (bus.edge_mode)
            2'b00:   qual = rise;
            2'b01:   qual = fall;
            2'b10:   qual = rise | fall;
            default: qual = 8'h00;
        endcase
        if (sup_q != 3'd0) qual = 8'h00;
    end

    always_comb begin
        acc_sum  = acc_q;
        aovf_sum = aovf_q;
        for (int i = 0; i < 8; i++) begin
            if (qual[i]) begin
                if (acc_q[i] == 16'hFFFF) aovf_sum[i] = 1'b1;
                else                      acc_sum[i]  = acc_q[i] + 16'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        acc_d   = acc_q;
        aovf_d  = aovf_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                if (bus.enable && bus.gate_len != 32'd0) begin
                    state_d = RUN;
                    timer_d = bus.gate_len - 32'd1;
                    acc_d   = '0;
                    aovf_d  = '0;
                end
            end
            RUN: begin
                if (!bus.enable || bus.gate_len == 32'd0) begin
                    state_d = IDLE;
                end else if (timer_q == 32'd0) begin
                    count_d = acc_sum;
                    ovf_d   = aovf_sum;
                    done_d  = 1'b1;
                    wcnt_d  = wcnt_q + 16'd1;
                    acc_d   = '0;
                    aovf_d  = '0;
                    timer_d = bus.gate_len - 32'd1;
                end else begin
                    timer_d = timer_q - 32'd1;
                    acc_d   = acc_sum;
                    aovf_d  = aovf_sum;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sync1_q <= '0;
            sync2_q <= '0;
            hist_q  <= '0;
            sup_q   <= SUPPRESS_CYCLES;
            timer_q <= '0;
            acc_q   <= '0;
            aovf_q  <= '0;
            count_q <= '0;
            ovf_q   <= '0;
            done_q  <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
            sup_q   <= sup_d;
            timer_q <= timer_d;
            acc_q   <= acc_d;
            aovf_q  <= aovf_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            wcnt_q  <= wcnt_d;
        end
    end

`ifdef DIO_EDGE_GLITCH_FILTER_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            h1_q <= '0;
            h2_q <= '0;
        end else begin
            h1_q <= h1_d;
            h2_q <= h2_d;
        end
    end
`endif

    assign bus.count_bus  = count_q;
    assign bus.ovf        = ovf_q;
    assign bus.done       = done_q;
    assign bus.window_cnt = wcnt_q;
endmodule

// File: tb/tb_dio_edge_counter.sv
// Directed bench for dio_edge_counter; expected values are hand-derived constants.
module tb_dio_edge_counter;
    logic       clk = 1'b0;
    logic       reset;
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         tog_per = 0;
    logic [2:0] tog_pin = 3'd0;
    int         exp_wc = 0;
    int         at1, at2, c0, seen, sum;

    dio_edge_counter_if bus ();
    dio_edge_counter dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock: sample point is the falling edge, then the toggle generator updates its pin
    task automatic step();
        @(negedge clk);
        cyc++;
        if (tog_per != 0 && (cyc % tog_per) == 0)
            bus.dio_in[tog_pin] = ~bus.dio_in[tog_pin];
    endtask

    task automatic run_to_done(input string tag, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (bus.done === 1'b1) begin
                at = cyc;
                break;
            end
        end
        exp_wc = (exp_wc + 1) % 65536;
        check({tag, "_done_seen"}, 128'(at >= 0), 128'd1);
    endtask

    function automatic logic [127:0] pin_cnt(input int pin, input logic [15:0] v);
        return 128'(v) << (16 * pin);
    endfunction

    initial begin
        reset         = 1'b1;
        bus.dio_in    = 8'h00;
        bus.enable    = 1'b0;
        bus.edge_mode = 2'b00;
        bus.gate_len  = 32'd0;
        repeat (3) step();
        check("rst_count", bus.count_bus, 128'd0);
        check("rst_ovf", 128'(bus.ovf), 128'd0);
        check("rst_done", 128'(bus.done), 128'd0);
        check("rst_wcnt", 128'(bus.window_cnt), 128'd0);

        // pins held high through reset release must not count
        bus.dio_in   = 8'hFF;
        bus.enable   = 1'b1;
        bus.gate_len = 32'd10;
        step();
        reset = 1'b0;
        c0 = cyc;
        run_to_done("hold_hi_w1", 30, at1);
        check("hold_hi_first_done", 128'(at1 - c0), 128'd11);
        check("hold_hi_cnt1", bus.count_bus, 128'd0);
        run_to_done("hold_hi_w2", 30, at2);
        check("hold_hi_period", 128'(at2 - at1), 128'd10);
        check("hold_hi_cnt2", bus.count_bus, 128'd0);
        check("hold_hi_wcnt", 128'(bus.window_cnt), 128'(exp_wc));

        // rising edges, pin 0 toggling every 5 cycles, 100-cycle windows
        bus.enable    = 1'b0;
        bus.dio_in    = 8'h00;
        bus.gate_len  = 32'd100;
        bus.edge_mode = 2'b00;
        tog_pin       = 3'd0;
        tog_per       = 5;
        repeat (5) step();
        bus.enable = 1'b1;
        run_to_done("rise_w1", 150, at1);
        run_to_done("rise_w2", 150, at2);
        check("rise_period", 128'(at2 - at1), 128'd100);
        check("rise_cnt", bus.count_bus, pin_cnt(0, 16'd10));
        check("rise_ovf", 128'(bus.ovf), 128'd0);
        step();
        check("done_one_cycle", 128'(bus.done), 128'd0);

        bus.edge_mode = 2'b10;
        run_to_done("both_mix", 150, at1);
        run_to_done("both_w", 150, at2);
        check("both_cnt", bus.count_bus, pin_cnt(0, 16'd20));
        bus.edge_mode = 2'b01;
        run_to_done("fall_mix", 150, at1);
        run_to_done("fall_w", 150, at2);
        check("fall_cnt", bus.count_bus, pin_cnt(0, 16'd10));
        bus.edge_mode = 2'b11;
        run_to_done("none_mix", 150, at1);
        run_to_done("none_w", 150, at2);
        check("none_cnt", bus.count_bus, 128'd0);
        bus.edge_mode = 2'b00;
        run_to_done("rise2_mix", 150, at1);
        run_to_done("rise2_w", 150, at2);
        check("rise2_cnt", bus.count_bus, pin_cnt(0, 16'd10));
        check("rise2_wcnt", 128'(bus.window_cnt), 128'(exp_wc));

        // drop enable halfway through a window
        repeat (50) step();
        bus.enable = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.done === 1'b1) seen++;
        end
        check("abort_no_done", 128'(seen), 128'd0);
        check("abort_cnt_hold", bus.count_bus, pin_cnt(0, 16'd10));
        check("abort_wcnt_hold", 128'(bus.window_cnt), 128'(exp_wc));
        bus.enable = 1'b1;
        c0 = cyc;
        run_to_done("reen", 150, at1);
        // one cycle to enter RUN, then a full 100-cycle window
        check("reen_latency", 128'(at1 - c0), 128'd101);
        check("reen_cnt", bus.count_bus, pin_cnt(0, 16'd10));

        // gate_len = 1: every cycle closes a window holding that cycle's edge
        bus.edge_mode = 2'b10;
        bus.gate_len  = 32'd1;
        run_to_done("gl1_enter", 110, at1);
        sum = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            exp_wc = (exp_wc + 1) % 65536;
            check("gl1_done", 128'(bus.done), 128'd1);
            sum += int'(bus.count_bus[15:0]);
        end
        check("gl1_edge_sum", 128'(sum), 128'd4);
        check("gl1_wcnt", 128'(bus.window_cnt), 128'(exp_wc));

        bus.gate_len = 32'd0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.done === 1'b1) seen++;
        end
        check("gl0_no_done", 128'(seen), 128'd0);

        // saturation on pin 3, then a quiet window clears it
        bus.enable = 1'b0;
        tog_per    = 0;
        step();
        tog_pin       = 3'd3;
        tog_per       = 1;
        bus.edge_mode = 2'b10;
        bus.gate_len  = 32'd65540;
        bus.enable    = 1'b1;
        run_to_done("sat", 70000, at1);
        check("sat_cnt", bus.count_bus, pin_cnt(3, 16'hFFFF));
        check("sat_ovf", 128'(bus.ovf), 128'h08);
        tog_per    = 0;
        bus.enable = 1'b0;
        repeat (6) step();
        bus.gate_len = 32'd10;
        bus.enable   = 1'b1;
        run_to_done("quiet", 20, at2);
        check("quiet_cnt", bus.count_bus, 128'd0);
        check("quiet_ovf", 128'(bus.ovf), 128'd0);
        check("quiet_wcnt", 128'(bus.window_cnt), 128'(exp_wc));

        // reset in the middle of a window
        repeat (4) step();
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.done === 1'b1) seen++;
        end
        check("midrst_no_done", 128'(seen), 128'd0);
        check("midrst_cnt", bus.count_bus, 128'd0);
        check("midrst_wcnt", 128'(bus.window_cnt), 128'd0);
        exp_wc = 0;

`ifdef DIO_EDGE_GLITCH_FILTER_EN
        bus.dio_in    = 8'h00;
        bus.edge_mode = 2'b00;
        bus.gate_len  = 32'd20;
        bus.enable    = 1'b1;
        reset = 1'b0;
        run_to_done("flt_align", 30, at1);
        repeat (2) step();
        bus.dio_in[7] = 1'b1;
        repeat (2) step();
        bus.dio_in[7] = 1'b0;
        run_to_done("flt_glitch", 30, at1);
        check("flt_glitch_cnt", bus.count_bus, 128'd0);
        repeat (2) step();
        bus.dio_in[7] = 1'b1;
        repeat (3) step();
        bus.dio_in[7] = 1'b0;
        run_to_done("flt_pulse", 30, at1);
        check("flt_pulse_cnt", bus.count_bus, pin_cnt(7, 16'd1));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
